// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/restoring_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module restoring_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        borrow  = (shifted < {1'b0, div_i});
        // When there is no borrow the true difference is below the divisor, so it fits WIDTH bits.
        diff    = shifted[WIDTH-1:0] - div_i;
        q_o     = ~borrow;
        rem_o   = borrow ? shifted[WIDTH-1:0] : diff;
    end

endmodule

// File: rtl/divider_32.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define DIV0_DETECT_EN to add the dz port and a single-cycle divide-by-zero shortcut.
module divider_32
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
`ifdef DIV0_DETECT_EN
    output logic             dz,
`endif
    output logic [WIDTH-1:0] r
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  dvd_q;
    logic [WIDTH-1:0]  div_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  quot_q;
    logic [WIDTH-1:0]  res_r_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  step_rem;
    logic              step_bit;
    logic              div0;

`ifdef DIV0_DETECT_EN
    logic              dz_q;
    assign div0 = (y == '0);
    assign dz   = dz_q;
`else
    assign div0 = 1'b0;
`endif

    restoring_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

    // dvd_q shifts left each step: dividend bits leave at the top, quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            res_r_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV0_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q <= x;
                        div_q <= y;
                        rem_q <= '0;
                        cnt_q <= CntW'(WIDTH - 1);
`ifdef DIV0_DETECT_EN
                        dz_q  <= div0;
`endif
                        if (div0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            res_r_q <= x;
                        end else begin
                            state_q <= StBusy;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_bit};
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= {dvd_q[WIDTH-2:0], step_bit};
                        res_r_q <= step_rem;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = quot_q;
    assign r    = res_r_q;

endmodule
